// File: rtl/pcpi_arb_pkg.sv
// pcpi_arb_pkg
//   Shared definitions for the PCPI arbiter:
//   - arb_state_t  : arbiter FSM states
//   - SLV_*        : slave bit positions in the per-slave vectors
//   - NUM_SLV      : number of co-processor slots
//   - TO_W         : width of the unclaimed-request timeout counter
//   - slv_word()   : picks one 32-bit slave word with a one-hot select
package pcpi_arb_pkg;

   localparam int NUM_SLV = 3;
   localparam int TO_W    = 8;

   localparam int SLV_EXT = 0;
   localparam int SLV_MUL = 1;
   localparam int SLV_DIV = 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PROBE = 3'd1,
      BUSY  = 3'd2,
      RESP  = 3'd3,
      DONE  = 3'd4
   } arb_state_t;

   // AND-OR mux; sel is one-hot (or zero, which yields zero).
   function automatic logic [31:0] slv_word(input logic [NUM_SLV-1:0]    sel,
                                            input logic [32*NUM_SLV-1:0] words);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (sel[i]) r = r | words[32*i +: 32];
      end
      return r;
   endfunction

endpackage

// File: rtl/pcpi_arb_prio.sv
// pcpi_arb_prio
//   Fixed-priority one-hot selector for the co-processor claim vector.
//   Priority: EXT (bit 0) > MUL (bit 1) > DIV (bit 2).
// Ports:
//   claim  in  NUM_SLV  per-slave claim (wait or ready, already enable-masked)
//   grant  out NUM_SLV  one-hot winner, zero when nobody claims
//   found  out 1        at least one claim present
module pcpi_arb_prio
   import pcpi_arb_pkg::*;
(
   input  logic [NUM_SLV-1:0] claim,
   output logic [NUM_SLV-1:0] grant,
   output logic               found
);

   always_comb begin
      grant = '0;
      found = |claim;
      if (claim[SLV_EXT])      grant[SLV_EXT] = 1'b1;
      else if (claim[SLV_MUL]) grant[SLV_MUL] = 1'b1;
      else if (claim[SLV_DIV]) grant[SLV_DIV] = 1'b1;
   end

endmodule

// File: rtl/pcpi_arbiter.sv
// pcpi_arbiter
//   Sequencing arbiter between the PicoRV32 PCPI port and the EXT (CGRA),
//   MUL and DIV co-processors. A request is broadcast to the enabled slaves,
//   the highest-priority claimant becomes owner, and its result is returned
//   through registered core-side outputs. Requests nobody claims within
//   TIMEOUT_CYCLES cycles produce a one-cycle pcpi_timeout pulse.
//
//   Optional feature macro: PCPI_ARB_PERF_EN
//     defined     -> four 32-bit wrapping counters on perf_cnt
//                    ([31:0] EXT, [63:32] MUL, [95:64] DIV completions,
//                     [127:96] timeouts)
//     not defined -> perf_cnt tied to zero, no counter flops
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   pcpi_valid/insn/rs1/rs2      core request (insn/operands reach the
//                                slaves directly on the shared bus)
//   pcpi_wr/rd/wait/ready        registered response to the core
//   pcpi_timeout                 one-cycle pulse: request unclaimed
//   cop_valid                    per-slave valid (bit0 EXT, bit1 MUL, bit2 DIV)
//   cop_wr/rd/wait/ready         per-slave response, slave i on rd[32i+31:32i]
//   perf_cnt                     performance counters
module pcpi_arbiter
   import pcpi_arb_pkg::*;
#(
   parameter bit          ENABLE_EXT     = 1'b1,
   parameter bit          ENABLE_MUL     = 1'b1,
   parameter bit          ENABLE_DIV     = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES = 16     // legal range 2..255
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   pcpi_valid,
   input  logic [31:0]            pcpi_insn,
   input  logic [31:0]            pcpi_rs1,
   input  logic [31:0]            pcpi_rs2,
   output logic                   pcpi_wr,
   output logic [31:0]            pcpi_rd,
   output logic                   pcpi_wait,
   output logic                   pcpi_ready,
   output logic                   pcpi_timeout,
   output logic [NUM_SLV-1:0]     cop_valid,
   input  logic [NUM_SLV-1:0]     cop_wr,
   input  logic [32*NUM_SLV-1:0]  cop_rd,
   input  logic [NUM_SLV-1:0]     cop_wait,
   input  logic [NUM_SLV-1:0]     cop_ready,
   output logic [127:0]           perf_cnt
);

   localparam logic [NUM_SLV-1:0] EN_MASK = {ENABLE_DIV, ENABLE_MUL, ENABLE_EXT};
   localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   arb_state_t          state, state_nxt;
   logic [NUM_SLV-1:0]  owner, owner_nxt;
   logic [TO_W-1:0]     to_cnt, to_cnt_nxt;

   logic [NUM_SLV-1:0]  claim, grant;
   logic                found;
   logic                grant_ready, owner_ready, to_expire;

   // Result capture controls produced by the next-state logic.
   logic                take;
   logic [NUM_SLV-1:0]  take_sel;
   logic                timeout_evt;

   // Instruction and operands go to the slaves on the shared bus; the
   // arbiter itself never decodes them.
   logic unused_fwd;
   assign unused_fwd = ^{pcpi_insn, pcpi_rs1, pcpi_rs2};

   // Disabled slaves can never claim.
   assign claim       = (cop_wait | cop_ready) & EN_MASK;
   assign grant_ready = |(grant & cop_ready);
   assign owner_ready = |(owner & cop_ready);
   assign to_expire   = (to_cnt == TO_LAST);

   pcpi_arb_prio u_prio (
      .claim (claim),
      .grant (grant),
      .found (found)
   );

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         owner  <= '0;
         to_cnt <= '0;
      end else begin
         state  <= state_nxt;
         owner  <= owner_nxt;
         to_cnt <= to_cnt_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt   = state;
      owner_nxt   = owner;
      to_cnt_nxt  = to_cnt;
      take        = 1'b0;
      take_sel    = '0;
      timeout_evt = 1'b0;
      case (state)
         IDLE: begin
            if (pcpi_valid) begin
               state_nxt  = PROBE;
               to_cnt_nxt = '0;
            end
         end
         PROBE: begin
            // Abort beats everything; a claim in the expiry cycle beats timeout.
            if (!pcpi_valid) begin
               state_nxt = IDLE;
            end else if (found) begin
               owner_nxt = grant;
               if (grant_ready) begin
                  state_nxt = RESP;
                  take      = 1'b1;
                  take_sel  = grant;
               end else begin
                  state_nxt = BUSY;
               end
            end else if (to_expire) begin
               state_nxt   = DONE;
               timeout_evt = 1'b1;
            end else begin
               to_cnt_nxt = to_cnt + 1'b1;
            end
         end
         BUSY: begin
            if (!pcpi_valid) begin
               state_nxt = IDLE;
            end else if (owner_ready) begin
               state_nxt = RESP;
               take      = 1'b1;
               take_sel  = owner;
            end
         end
         RESP: state_nxt = DONE;
         DONE: begin
            if (!pcpi_valid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: slave valids are combinational so an async reset
   // drops them immediately.
   always_comb begin
      cop_valid = '0;
      case (state)
         PROBE:   cop_valid = {NUM_SLV{pcpi_valid}} & EN_MASK;
         BUSY:    cop_valid = {NUM_SLV{pcpi_valid}} & owner;
         default: cop_valid = '0;
      endcase
   end

   // Registered core-side outputs; pcpi_rd holds through DONE and beyond.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pcpi_wr      <= 1'b0;
         pcpi_rd      <= '0;
         pcpi_wait    <= 1'b0;
         pcpi_ready   <= 1'b0;
         pcpi_timeout <= 1'b0;
      end else begin
         pcpi_ready   <= take;
         pcpi_wr      <= take & |(take_sel & cop_wr);
         pcpi_wait    <= (state_nxt == BUSY);
         pcpi_timeout <= timeout_evt;
         if (take) pcpi_rd <= slv_word(take_sel, cop_rd);
      end
   end

`ifdef PCPI_ARB_PERF_EN
   logic [31:0] cnt_ext, cnt_mul, cnt_div, cnt_to;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_ext <= '0;
         cnt_mul <= '0;
         cnt_div <= '0;
         cnt_to  <= '0;
      end else begin
         if (take && take_sel[SLV_EXT]) cnt_ext <= cnt_ext + 32'd1;
         if (take && take_sel[SLV_MUL]) cnt_mul <= cnt_mul + 32'd1;
         if (take && take_sel[SLV_DIV]) cnt_div <= cnt_div + 32'd1;
         if (timeout_evt)               cnt_to  <= cnt_to + 32'd1;
      end
   end

   assign perf_cnt = {cnt_to, cnt_div, cnt_mul, cnt_ext};
`else
   assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_pcpi_arbiter.sv
// tb_pcpi_arbiter
//   Directed bench for pcpi_arbiter with default parameters
//   (EXT and MUL enabled, DIV disabled, TIMEOUT_CYCLES = 16).
//   Expected responses are queued when the claiming stimulus is driven and
//   retired by a monitor whenever pcpi_ready or pcpi_timeout pulses.
//   Honours PCPI_ARB_PERF_EN for the perf_cnt expectations.
module tb_pcpi_arbiter;

   logic          clk;
   logic          resetn;
   logic          pcpi_valid;
   logic [31:0]   pcpi_insn, pcpi_rs1, pcpi_rs2;
   logic          pcpi_wr;
   logic [31:0]   pcpi_rd;
   logic          pcpi_wait, pcpi_ready, pcpi_timeout;
   logic [2:0]    cop_valid;
   logic [2:0]    cop_wr;
   logic [95:0]   cop_rd;
   logic [2:0]    cop_wait, cop_ready;
   logic [127:0]  perf_cnt;

   typedef struct {
      bit          is_to;
      logic        wr;
      logic [31:0] rd;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   pcpi_arbiter dut (
      .clk          (clk),
      .resetn       (resetn),
      .pcpi_valid   (pcpi_valid),
      .pcpi_insn    (pcpi_insn),
      .pcpi_rs1     (pcpi_rs1),
      .pcpi_rs2     (pcpi_rs2),
      .pcpi_wr      (pcpi_wr),
      .pcpi_rd      (pcpi_rd),
      .pcpi_wait    (pcpi_wait),
      .pcpi_ready   (pcpi_ready),
      .pcpi_timeout (pcpi_timeout),
      .cop_valid    (cop_valid),
      .cop_wr       (cop_wr),
      .cop_rd       (cop_rd),
      .cop_wait     (cop_wait),
      .cop_ready    (cop_ready),
      .perf_cnt     (perf_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change just after the rising edge; outputs are sampled at the falling edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic push_resp(input logic wr, input logic [31:0] rd);
      exp_t e;
      e.is_to = 1'b0;
      e.wr    = wr;
      e.rd    = rd;
      sb.push_back(e);
   endtask

   task automatic push_to();
      exp_t e;
      e.is_to = 1'b1;
      e.wr    = 1'b0;
      e.rd    = '0;
      sb.push_back(e);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (pcpi_ready === 1'b1 || pcpi_timeout === 1'b1) begin
         chk("sb_ready_and_timeout", {127'd0, pcpi_ready & pcpi_timeout}, 128'd0);
         if (sb.size() == 0) begin
            chk("sb_unexpected_evt", {126'd0, pcpi_ready, pcpi_timeout}, 128'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_kind_timeout", {127'd0, pcpi_timeout}, {127'd0, e.is_to});
            if (!e.is_to) begin
               chk("sb_rd", {96'd0, pcpi_rd}, {96'd0, e.rd});
               chk("sb_wr", {127'd0, pcpi_wr}, {127'd0, e.wr});
            end
         end
      end
   end

   // Request answered by an immediate ready in the first PROBE cycle.
   task automatic run_immediate(input logic [2:0] rdy, input logic [2:0] wr,
                                input logic [31:0] rd_ext, input logic [31:0] rd_mul,
                                input logic exp_wr, input logic [31:0] exp_rd);
      cyc();
      pcpi_valid = 1'b1;
      pcpi_insn  = $urandom;
      pcpi_rs1   = $urandom;
      pcpi_rs2   = $urandom;
      mid();
      chk("imm_idle_cv", cop_valid, 3'b000);
      cyc();
      cop_ready       = rdy;
      cop_wr          = wr;
      cop_rd[31:0]    = rd_ext;
      cop_rd[63:32]   = rd_mul;
      push_resp(exp_wr, exp_rd);
      mid();
      chk("imm_probe_cv", cop_valid, 3'b011);
      chk("imm_probe_rdy", pcpi_ready, 1'b0);
      cyc();
      cop_ready = '0;
      cop_wr    = '0;
      cop_rd    = {96{1'b1}};
      mid();
      chk("imm_resp_rdy", pcpi_ready, 1'b1);
      chk("imm_resp_rd", pcpi_rd, exp_rd);
      chk("imm_resp_wr", pcpi_wr, exp_wr);
      chk("imm_resp_cv", cop_valid, 3'b000);
      chk("imm_resp_wait", pcpi_wait, 1'b0);
      cyc();
      pcpi_valid = 1'b0;
      mid();
      chk("imm_done_rdy", pcpi_ready, 1'b0);
      chk("imm_done_wr", pcpi_wr, 1'b0);
      chk("imm_done_rd", pcpi_rd, exp_rd);
      cyc();
      cop_rd = '0;
      mid();
   endtask

   // Watchdog
   initial begin
      repeat (5000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded 5000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] perf_exp;

      resetn     = 1'b0;
      pcpi_valid = 1'b0;
      pcpi_insn  = '0;
      pcpi_rs1   = '0;
      pcpi_rs2   = '0;
      cop_wr     = '0;
      cop_rd     = '0;
      cop_wait   = '0;
      cop_ready  = '0;

      // Reset state
      repeat (2) cyc();
      mid();
      chk("rst_ctrl", {pcpi_wr, pcpi_wait, pcpi_ready, pcpi_timeout, cop_valid}, 7'd0);
      chk("rst_rd", pcpi_rd, 32'd0);
      chk("rst_perf", perf_cnt, 128'd0);
      cyc();
      resetn = 1'b1;
      mid();

      // A: MUL answers immediately
      run_immediate(3'b010, 3'b010, 32'h0, 32'h0000_0042, 1'b1, 32'h0000_0042);

      // B: EXT waits 10 cycles, then ready; MUL noise while BUSY is ignored
      cyc();
      pcpi_valid = 1'b1;
      mid();
      cyc();
      cop_wait = 3'b001;
      mid();
      chk("b_probe_cv", cop_valid, 3'b011);
      chk("b_probe_wait", pcpi_wait, 1'b0);
      for (int k = 2; k <= 10; k++) begin
         cyc();
         if (k == 3) begin
            cop_ready     = 3'b010;
            cop_wr        = 3'b010;
            cop_rd[63:32] = 32'h1111_1111;
         end else if (k == 4) begin
            cop_ready = '0;
            cop_wr    = '0;
         end
         mid();
         chk("b_busy_wait", pcpi_wait, 1'b1);
         chk("b_busy_cv", cop_valid, 3'b001);
         chk("b_busy_rdy", pcpi_ready, 1'b0);
      end
      cyc();
      cop_wait     = '0;
      cop_ready    = 3'b001;
      cop_wr       = 3'b001;
      cop_rd[31:0] = 32'hDEAD_BEEF;
      push_resp(1'b1, 32'hDEAD_BEEF);
      mid();
      chk("b_last_wait", pcpi_wait, 1'b1);
      cyc();
      cop_ready = '0;
      cop_wr    = '0;
      mid();
      chk("b_resp_rdy", pcpi_ready, 1'b1);
      chk("b_resp_rd", pcpi_rd, 32'hDEAD_BEEF);
      chk("b_resp_wait", pcpi_wait, 1'b0);
      chk("b_resp_cv", cop_valid, 3'b000);
      cyc();
      pcpi_valid = 1'b0;
      mid();
      chk("b_done_rdy", pcpi_ready, 1'b0);
      cyc();
      mid();

      // C: EXT and MUL ready together -> EXT owns, MUL result dropped
      run_immediate(3'b011, 3'b010, 32'hAAAA_0001, 32'hBBBB_0002, 1'b0, 32'hAAAA_0001);

      // D: nobody claims (disabled DIV asserts ready) -> timeout at cycle 17
      cyc();
      pcpi_valid = 1'b1;
      mid();
      cyc();
      cop_ready    = 3'b100;
      cop_wr       = 3'b100;
      cop_rd[95:64] = 32'h5555_5555;
      push_to();
      for (int k = 1; k <= 16; k++) begin
         mid();
         chk("d_probe_cv", cop_valid, 3'b011);
         chk("d_no_timeout", pcpi_timeout, 1'b0);
         cyc();
      end
      mid();
      chk("d_timeout", pcpi_timeout, 1'b1);
      chk("d_timeout_rdy", pcpi_ready, 1'b0);
      cyc();
      cop_ready = '0;
      cop_wr    = '0;
      mid();
      chk("d_timeout_pulse", pcpi_timeout, 1'b0);
      chk("d_done_cv", cop_valid, 3'b000);
      cyc();
      pcpi_valid = 1'b0;
      mid();
      cyc();
      mid();

      // E: claim arrives in the expiry cycle -> ready wins, no timeout
      cyc();
      pcpi_valid = 1'b1;
      cyc();
      repeat (15) cyc();
      cop_ready     = 3'b010;
      cop_wr        = 3'b000;
      cop_rd[63:32] = 32'h0000_0E0E;
      push_resp(1'b0, 32'h0000_0E0E);
      mid();
      chk("e_expiry_no_to", pcpi_timeout, 1'b0);
      cyc();
      cop_ready = '0;
      mid();
      chk("e_rdy", pcpi_ready, 1'b1);
      chk("e_no_to", pcpi_timeout, 1'b0);
      cyc();
      mid();
      chk("e_after_no_to", pcpi_timeout, 1'b0);
      cyc();
      pcpi_valid = 1'b0;
      mid();
      cyc();
      mid();

      // F: valid dropped in BUSY while owner ready arrives -> discarded
      cyc();
      pcpi_valid = 1'b1;
      cyc();
      cop_wait = 3'b001;
      cyc();
      mid();
      chk("f_busy_cv", cop_valid, 3'b001);
      cyc();
      pcpi_valid   = 1'b0;
      cop_wait     = '0;
      cop_ready    = 3'b001;
      cop_wr       = 3'b001;
      cop_rd[31:0] = 32'hBAD0_BAD0;
      mid();
      chk("f_abort_cv", cop_valid, 3'b000);
      cyc();
      cop_ready = '0;
      cop_wr    = '0;
      mid();
      chk("f_no_rdy", pcpi_ready, 1'b0);
      chk("f_no_wait", pcpi_wait, 1'b0);
      chk("f_idle_cv", cop_valid, 3'b000);
      chk("f_rd_held", pcpi_rd, 32'h0000_0E0E);
      cyc();
      mid();

`ifdef PCPI_ARB_PERF_EN
      perf_exp = {32'd1, 32'd0, 32'd2, 32'd2};
`else
      perf_exp = '0;
`endif
      chk("perf_before_reset", perf_cnt, perf_exp);

      // G: reset while BUSY -> outputs drop at once; next request completes
      cyc();
      pcpi_valid = 1'b1;
      cyc();
      cop_wait = 3'b001;
      cyc();
      mid();
      chk("g_busy_cv", cop_valid, 3'b001);
      chk("g_busy_wait", pcpi_wait, 1'b1);
      #1;
      resetn = 1'b0;
      #1;
      chk("g_rst_cv", cop_valid, 3'b000);
      chk("g_rst_ctrl", {pcpi_wr, pcpi_wait, pcpi_ready, pcpi_timeout}, 4'd0);
      chk("g_rst_rd", pcpi_rd, 32'd0);
      chk("g_rst_perf", perf_cnt, 128'd0);
      cyc();
      resetn     = 1'b1;
      pcpi_valid = 1'b0;
      cop_wait   = '0;
      mid();
      run_immediate(3'b010, 3'b010, 32'h0, 32'h0000_0077, 1'b1, 32'h0000_0077);

`ifdef PCPI_ARB_PERF_EN
      perf_exp = {32'd0, 32'd0, 32'd1, 32'd0};
`else
      perf_exp = '0;
`endif
      chk("perf_after_reset", perf_cnt, perf_exp);

      repeat (2) cyc();
      mid();
      chk("sb_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pcpi_arbiter.md
# pcpi_arbiter

Sequencing arbiter between the PicoRV32 core's PCPI port and three co-processors: the external CGRA unit (EXT), the multiplier (MUL) and the divider (DIV). It broadcasts each PCPI request to the enabled co-processors and locks onto the first one that claims it. It returns that unit's result to the core through registered outputs and flags instructions that no unit claims within a bounded window. It replaces the combinational PCPI result mux inside the core wrapper.

## Interface
- ENABLE_EXT, 1, EXT slave present; if 0, its inputs are ignored and its valid is held 0
- ENABLE_MUL, 1, MUL slave present (same rule)
- ENABLE_DIV, 0, DIV slave present (same rule)
- TIMEOUT_CYCLES, 16, unclaimed-request window in cycles; legal range 2..255

- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- pcpi_valid  in  1  core request
- pcpi_insn  in  32  instruction; forwarded unchanged to all slaves
- pcpi_rs1, pcpi_rs2  in  32  operands; forwarded unchanged to all slaves
- pcpi_wr  out  1  result write-enable to core
- pcpi_rd  out  32  result to core
- pcpi_wait  out  1  a slave owns the request
- pcpi_ready  out  1  one-cycle completion pulse
- pcpi_timeout  out  1  one-cycle pulse: no slave claimed (illegal instruction)
- cop_valid  out  3  per-slave valid; bit 0 EXT, bit 1 MUL, bit 2 DIV
- cop_wr  in  3  per-slave write-enable
- cop_rd  in  96  per-slave result; slave i on bits [32i+31:32i]
- cop_wait, cop_ready  in  3  per-slave handshake
- perf_cnt  out  128  performance counters (see Configuration)

## Operation
- States: IDLE, PROBE, BUSY, RESP, DONE.
- IDLE: when pcpi_valid=1, go to PROBE and clear the timeout counter.
- PROBE: cop_valid = pcpi_valid & enable mask.
  - Claim = any enabled cop_wait or cop_ready.
  - The owner is the highest-priority claimant. Priority order is EXT > MUL > DIV.
  - Claim with ready: latch the owner's cop_wr and cop_rd, go to RESP.
  - Claim with wait only: record the owner, go to BUSY.
  - No claim for TIMEOUT_CYCLES cycles: pulse pcpi_timeout, go to DONE.
  - A claim in the same cycle as expiry wins; no timeout is raised.
- BUSY: cop_valid is one-hot to the owner; pcpi_wait=1.
  - Owner cop_ready: latch cop_wr and cop_rd, go to RESP.
  - Wait and ready from non-owners are ignored.
  - BUSY has no timeout.
- RESP: pcpi_ready=1 for exactly one cycle, with pcpi_wr and pcpi_rd from the latched values; cop_valid=0. Then go to DONE.
- DONE: hold pcpi_rd; pcpi_wr=0. Go to IDLE when pcpi_valid=0, so back-to-back requests need a valid drop.
- Abort: pcpi_valid=0 in PROBE or BUSY means go to IDLE with no ready and no timeout. A ready arriving in the same cycle as the abort is discarded.
- No slave enabled: every request times out.

## Timing
- Reset values: pcpi_wr=0, pcpi_rd=0, pcpi_wait=0, pcpi_ready=0, pcpi_timeout=0, cop_valid=0, perf_cnt=0, state IDLE.
- Reset mid-operation: cop_valid drops immediately (asynchronous); the request is lost.
- cop_valid is combinational from the state register, pcpi_valid and the owner register. It rises in the cycle after pcpi_valid rises.
- All core-side outputs are registered.
  - Slave ready in cycle N gives pcpi_ready in cycle N+1.
  - pcpi_wait rises the cycle after the claim.
- Minimum latency from pcpi_valid to pcpi_ready is 3 cycles (IDLE, PROBE with immediate ready, RESP).
- Timeout pulse is asserted TIMEOUT_CYCLES+1 cycles after pcpi_valid rises.

## Configuration
- PCPI_ARB_PERF_EN defined: four 32-bit wrapping counters on perf_cnt.
  - [31:0] EXT completions
  - [63:32] MUL completions
  - [95:64] DIV completions
  - [127:96] timeouts
  - Each counter increments on its RESP or timeout event.
- PCPI_ARB_PERF_EN not defined: perf_cnt is tied to 0 and no counter flops exist.

## Structure
- Package pcpi_arb_pkg holds:
  - state enum arb_state_t
  - slave index constants SLV_EXT=0, SLV_MUL=1, SLV_DIV=2
  - NUM_SLV=3
  - TO_W=8 (timeout counter width)
- Sub-module pcpi_arb_prio: combinational fixed-priority one-hot select of a 3-bit claim vector, plus a found flag.

## Test plan
- MUL only enabled; cop_ready[1]=1 with cop_rd=0x0000_0042, cop_wr=1 in the first PROBE cycle -> one pcpi_ready pulse 3 cycles after valid, pcpi_rd=0x42, pcpi_wr=1.
- EXT asserts wait for 10 cycles, then ready with rd=0xDEAD_BEEF -> pcpi_wait high throughout, cop_valid=3'b001 in BUSY, pcpi_ready the cycle after cop_ready.
- EXT and MUL both ready in the same PROBE cycle -> owner is EXT; MUL result discarded.
- No claim, TIMEOUT_CYCLES=16 -> pcpi_timeout pulses at cycle 17, no ready; with PCPI_ARB_PERF_EN the timeout counter reads 1.
- pcpi_valid dropped in BUSY while the owner's ready arrives -> no pcpi_ready, return to IDLE, cop_valid=0.
- resetn asserted in BUSY -> all outputs 0 immediately; a new request afterwards completes normally.
